// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART frame constants, FSM state type and parity helper
package uart_pkg;

    localparam int DATA_BITS = 8;

    // Parity convention shared with the transmitter: 0 selects even parity.
    localparam logic PARITY_ODD = 1'b0;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_IDLE = 3'd5
    } uart_state_t;

    // Expected parity bit for a data byte under the shared convention.
    function automatic logic parity_of(input logic [DATA_BITS-1:0] data);
        return (^data) ^ PARITY_ODD;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - two-flop synchronizer for the asynchronous serial line
module uart_rx_sync (
    input  logic clk,
    input  logic reset,
    input  logic serial,
    output logic synced
);

    logic meta;

    // Preset high so reset release looks like an idle line, never a start bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta   <= 1'b1;
            synced <= 1'b1;
        end else begin
            meta   <= serial;
            synced <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receiver: 8 data bits LSB first, even parity, one stop bit
module uart_rx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_data_in,
    output logic [7:0] rx_data_out,
    output logic       rx_valid,
    output logic       rx_busy,
    output logic       parity_err,
    output logic       frame_err
);

    import uart_pkg::*;

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

    uart_state_t          state, state_next;
    logic                 rx_s;
    logic [CW-1:0]        cnt;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit;
    logic                 half_tick, full_tick;
    logic                 cnt_clear, shift_en, par_en, stop_en;

    uart_rx_sync u_sync (
        .clk    (clk),
        .reset  (reset),
        .serial (rx_data_in),
        .synced (rx_s)
    );

    assign half_tick = (cnt == HALF_LAST);
    assign full_tick = (cnt == FULL_LAST);
    assign rx_busy   = (state != IDLE);

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state decode and per-cycle sampling strobes.
    always_comb begin
        state_next = state;
        shift_en   = 1'b0;
        par_en     = 1'b0;
        stop_en    = 1'b0;
        case (state)
            IDLE:      if (!rx_s) state_next = START;
            START:     if (half_tick) state_next = rx_s ? IDLE : DATA;
            DATA: begin
                if (full_tick) begin
                    shift_en = 1'b1;
                    if (bit_cnt == LAST_BIT) state_next = PARITY;
                end
            end
            PARITY: begin
                if (full_tick) begin
                    par_en     = 1'b1;
                    state_next = STOP;
                end
            end
            STOP: begin
                if (full_tick) begin
                    stop_en    = 1'b1;
                    state_next = rx_s ? IDLE : WAIT_IDLE;
                end
            end
            WAIT_IDLE: if (rx_s) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
        // The bit-period counter restarts on every state change and at each bit boundary.
        cnt_clear = (state_next != state) || full_tick ||
                    (state == IDLE) || (state == WAIT_IDLE);
    end

    // Bit-period counter and data-bit index.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt     <= '0;
            bit_cnt <= '0;
        end else begin
            cnt <= cnt_clear ? '0 : cnt + CW'(1);
            if (state == IDLE)  bit_cnt <= '0;
            else if (shift_en)  bit_cnt <= bit_cnt + BW'(1);
        end
    end

    // Shift register, captured parity bit and registered frame-complete outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shreg       <= '0;
            par_bit     <= 1'b0;
            rx_data_out <= 8'h00;
            rx_valid    <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            if (shift_en) shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
            if (par_en)   par_bit <= rx_s;
            if (stop_en) begin
                rx_data_out <= shreg;
                rx_valid    <= 1'b1;
                parity_err  <= (par_bit != parity_of(shreg));
                frame_err   <= !rx_s;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed self-checking bench for uart_rx
module tb_uart_rx;

    localparam int CPB = 16;
    // Line edge to stop-sample edge: 3 sync/detect edges + half bit + 10 bits.
    localparam int VALID_LAT = 3 + CPB / 2 + 10 * CPB;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rx_data_in = 1'b1;
    logic [7:0] rx_data_out;
    logic       rx_valid, rx_busy, parity_err, frame_err;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int valid_count = 0;
    int last_valid_cyc = 0;
    int stray_err = 0;
    logic [7:0] last_data = 8'h00;
    logic       last_perr = 1'b0;
    logic       last_ferr = 1'b0;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk         (clk),
        .reset       (reset),
        .rx_data_in  (rx_data_in),
        .rx_data_out (rx_data_out),
        .rx_valid    (rx_valid),
        .rx_busy     (rx_busy),
        .parity_err  (parity_err),
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_valid) begin
            valid_count    <= valid_count + 1;
            last_valid_cyc <= cyc;
            last_data      <= rx_data_out;
            last_perr      <= parity_err;
            last_ferr      <= frame_err;
        end else if (parity_err || frame_err) begin
            stray_err <= stray_err + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic drive_bit(input logic v);
        rx_data_in = v;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(par);
        drive_bit(stop);
    endtask

    initial begin
        int s;
        int v1;
        int base;
        logic [7:0] d;

        // Reset state
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("reset_data", 32'(rx_data_out), 32'h00);
        check("reset_valid", 32'(rx_valid), 32'h0);
        check("reset_busy", 32'(rx_busy), 32'h0);
        check("reset_perr", 32'(parity_err), 32'h0);
        check("reset_ferr", 32'(frame_err), 32'h0);
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (4) @(posedge clk); #1;

        // Clean 0xA5 frame with exact completion cycle
        base = valid_count; s = cyc;
        send_frame(8'hA5, 1'b0, 1'b1);
        check("a5_count", 32'(valid_count), 32'(base + 1));
        check("a5_data", 32'(last_data), 32'hA5);
        check("a5_perr", 32'(last_perr), 32'h0);
        check("a5_ferr", 32'(last_ferr), 32'h0);
        check("a5_cycle", 32'(last_valid_cyc), 32'(s + VALID_LAT));
        check("a5_busy_after", 32'(rx_busy), 32'h0);
        repeat (10) @(posedge clk); #1;
        check("a5_hold", 32'(rx_data_out), 32'hA5);

        // 0x01 with wrong (even) parity bit
        base = valid_count;
        send_frame(8'h01, 1'b0, 1'b1);
        check("p01_count", 32'(valid_count), 32'(base + 1));
        check("p01_data", 32'(last_data), 32'h01);
        check("p01_perr", 32'(last_perr), 32'h1);
        check("p01_ferr", 32'(last_ferr), 32'h0);

        // 0x3C with low stop bit, line held low, then recovery with 0x55
        base = valid_count;
        send_frame(8'h3C, 1'b0, 1'b0);
        check("f3c_count", 32'(valid_count), 32'(base + 1));
        check("f3c_data", 32'(last_data), 32'h3C);
        check("f3c_ferr", 32'(last_ferr), 32'h1);
        check("f3c_perr", 32'(last_perr), 32'h0);
        repeat (2 * CPB) @(posedge clk); #1;
        check("break_busy", 32'(rx_busy), 32'h1);
        check("break_no_frame", 32'(valid_count), 32'(base + 1));
        rx_data_in = 1'b1;
        repeat (CPB) @(posedge clk); #1;
        check("break_released", 32'(rx_busy), 32'h0);
        base = valid_count;
        send_frame(8'h55, 1'b0, 1'b1);
        check("r55_count", 32'(valid_count), 32'(base + 1));
        check("r55_data", 32'(last_data), 32'h55);
        check("r55_errs", 32'({last_perr, last_ferr}), 32'h0);

        // Short low glitch is rejected
        base = valid_count;
        rx_data_in = 1'b0;
        repeat (CPB / 4) @(posedge clk); #1;
        rx_data_in = 1'b1;
        @(negedge clk);
        check("glitch_busy", 32'(rx_busy), 32'h1);
        repeat (2 * CPB) @(posedge clk); #1;
        check("glitch_idle", 32'(rx_busy), 32'h0);
        check("glitch_no_valid", 32'(valid_count), 32'(base));
        check("glitch_hold", 32'(rx_data_out), 32'h55);

        // Reset during data bit 4 discards the frame
        base = valid_count;
        d = 8'hC3;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(d[i]);
        rx_data_in = d[4];
        repeat (CPB / 2) @(posedge clk); #1;
        check("mid_busy", 32'(rx_busy), 32'h1);
        reset = 1'b0;
        rx_data_in = 1'b1;
        #1;
        check("rst_data", 32'(rx_data_out), 32'h00);
        check("rst_busy", 32'(rx_busy), 32'h0);
        check("rst_valid", 32'(rx_valid), 32'h0);
        check("rst_errs", 32'({parity_err, frame_err}), 32'h0);
        repeat (3) @(posedge clk); #1;
        reset = 1'b1;
        repeat (4) @(posedge clk); #1;
        check("rst_no_valid", 32'(valid_count), 32'(base));
        send_frame(8'hC3, 1'b0, 1'b1);
        check("c3_count", 32'(valid_count), 32'(base + 1));
        check("c3_data", 32'(last_data), 32'hC3);
        check("c3_errs", 32'({last_perr, last_ferr}), 32'h0);

        // Back-to-back 0x00 then 0xFF with no idle gap
        base = valid_count; s = cyc;
        send_frame(8'h00, 1'b0, 1'b1);
        check("b00_data", 32'(last_data), 32'h00);
        check("b00_cycle", 32'(last_valid_cyc), 32'(s + VALID_LAT));
        v1 = last_valid_cyc;
        send_frame(8'hFF, 1'b0, 1'b1);
        check("bff_count", 32'(valid_count), 32'(base + 2));
        check("bff_data", 32'(last_data), 32'hFF);
        check("bff_errs", 32'({last_perr, last_ferr}), 32'h0);
        check("bff_spacing", 32'(last_valid_cyc - v1), 32'(11 * CPB));

        repeat (4) @(posedge clk); #1;
        check("no_stray_errs", 32'(stray_err), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 16, giving clock cycles per serial bit (legal: even values >= 4).
REQ-002 The block SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-003 The block SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL have port rx_data_in  input  1  asynchronous serial line, idle high.
REQ-005 The block SHALL have port rx_data_out  output  8  last received byte.
REQ-006 The block SHALL have port rx_valid  output  1  one-cycle pulse, frame complete.
REQ-007 The block SHALL have port rx_busy  output  1  high while a frame is being received.
REQ-008 The block SHALL have port parity_err  output  1  qualifies rx_valid, received parity mismatch.
REQ-009 The block SHALL have port frame_err  output  1  qualifies rx_valid, stop bit sampled low.

Function
REQ-010 The frame SHALL be: start bit 0, 8 data bits LSB first, even parity bit (XOR of the 8 data bits), stop bit 1.
REQ-011 rx_data_in SHALL pass through a 2-flop synchronizer; all logic uses the synchronized value rx_s.
REQ-012 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
REQ-013 IDLE: the first cycle with rx_s==0 (t0) SHALL move to START, clear the bit counter and assert rx_busy.
REQ-014 START: at t0+CLKS_PER_BIT/2 rx_s SHALL be sampled; 0 -> DATA, 1 -> IDLE (glitch reject, no rx_valid, rx_busy drops).
REQ-015 DATA bit i (0..7) SHALL be sampled at t0+CLKS_PER_BIT/2+(i+1)*CLKS_PER_BIT into shift register position i; after bit 7 -> PARITY.
REQ-016 PARITY SHALL be sampled at t0+CLKS_PER_BIT/2+9*CLKS_PER_BIT; mismatch with XOR of data sets parity error.
REQ-017 STOP SHALL be sampled at t0+CLKS_PER_BIT/2+10*CLKS_PER_BIT; on that edge rx_data_out, parity_err, frame_err update and rx_valid pulses for exactly one cycle.
REQ-018 rx_valid SHALL pulse for every frame that reaches STOP, including errored frames; parity_err/frame_err are valid only while rx_valid is high and are 0 otherwise.
REQ-019 Good stop bit -> IDLE, rx_busy low the same edge; back-to-back start bit is accepted with no idle gap.
REQ-020 Stop bit 0 -> WAIT_IDLE; the block SHALL NOT re-arm until rx_s==1 (break handling); rx_busy stays high in WAIT_IDLE.
REQ-021 rx_data_out SHALL hold its value between rx_valid pulses.
REQ-022 Bit-period counter width SHALL be $clog2(CLKS_PER_BIT); counter wraps to 0 at CLKS_PER_BIT-1.
REQ-023 Illegal state encodings SHALL return to IDLE.

Reset
REQ-024 On reset low, regardless of state, the block SHALL go to IDLE: rx_data_out=8'h00, rx_valid=0, rx_busy=0, parity_err=0, frame_err=0, counters 0.
REQ-025 Synchronizer flops SHALL reset to 1 so no false start is seen on reset release.
REQ-026 A frame interrupted by reset SHALL be discarded; no rx_valid for it.

Structure
REQ-027 The shared package uart_pkg SHALL hold the state enum, DATA_BITS=8 and the even-parity convention, shared with the transmitter.
REQ-028 The synchronizer SHALL be a sub-module uart_rx_sync; the FSM, counters and shift register stay in uart_rx.

Verification
REQ-029 Send 0xA5, parity 0, stop 1 -> one rx_valid, rx_data_out=0xA5, parity_err=0, frame_err=0, at the cycle in REQ-017.
REQ-030 Send 0x01 with parity bit 0 -> rx_valid, rx_data_out=0x01, parity_err=1, frame_err=0.
REQ-031 Send 0x3C with stop bit 0, line held low 3 bit periods -> rx_valid with frame_err=1; no new frame until line high, then 0x55 received correctly.
REQ-032 Low glitch of CLKS_PER_BIT/4 cycles -> rx_busy pulses, returns to IDLE, no rx_valid.
REQ-033 Reset asserted during data bit 4 -> all outputs 0 immediately; next frame 0xC3 received correctly.
REQ-034 Frames 0x00 and 0xFF back-to-back with no idle gap -> two rx_valid pulses 11*CLKS_PER_BIT cycles apart, correct data, no errors.
